// File: rtl/fetch_state_unit.sv
// Fetch/state front end of the multi-cycle core: holds PC, IR and the FSM state register,
// fetches over a req/ready handshake and applies branch/jump redirects in execute.
module fetch_state_unit #(
  parameter int                 STATE_W  = 3,
  parameter logic [31:0]        RESET_PC = 32'h0000_0000,
  parameter logic [STATE_W-1:0] S_IF     = 3'd0,
  parameter logic [STATE_W-1:0] S_ID     = 3'd1,
  parameter logic [STATE_W-1:0] S_EX     = 3'd2,
  parameter logic [STATE_W-1:0] S_MEM    = 3'd3,
  parameter logic [STATE_W-1:0] S_WB     = 3'd4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STATE_W-1:0] new_state,
  input  logic               branch_flag,
  input  logic               jump_flag,
  input  logic               alu_zero,
  input  logic [31:0]        imem_rdata,
  input  logic               imem_ready,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  output logic [31:0]        pc,
  output logic [31:0]        instr,
  output logic [5:0]         opcode,
  output logic [5:0]         funct,
  output logic [STATE_W-1:0] state,
  output logic               stall
);

  typedef enum logic [STATE_W-1:0] {
    ST_IF  = S_IF,
    ST_ID  = S_ID,
    ST_EX  = S_EX,
    ST_MEM = S_MEM,
    ST_WB  = S_WB
  } state_t;

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_t      state_r;
  state_t      next_state_s;
  logic [31:0] pc_r;
  logic [31:0] next_pc_s;
  logic [31:0] instr_r;
  logic        fetch_done_s;

  function automatic logic is_legal_state(input logic [STATE_W-1:0] s);
    logic legal;
    case (s)
      S_IF, S_ID, S_EX, S_MEM, S_WB: legal = 1'b1;
      default:                       legal = 1'b0;
    endcase
    return legal;
  endfunction

  function automatic logic [31:0] jump_target(input logic [31:0] cur_pc,
                                              input logic [31:0] ir);
    return {cur_pc[31:28], ir[25:0], 2'b00};
  endfunction

  function automatic logic [31:0] branch_target(input logic [31:0] cur_pc,
                                                input logic [31:0] ir);
    return cur_pc + {{14{ir[15]}}, ir[15:0], 2'b00};
  endfunction

  assign fetch_done_s = (state_r == ST_IF) && imem_ready;

  // Next-state decode: an out-of-range request from the control unit falls back to fetch.
  always_comb begin
    next_state_s = ST_IF;
    if (is_legal_state(new_state)) begin
      next_state_s = state_t'(new_state);
    end else begin
      next_state_s = ST_IF;
    end
  end

  // Next-PC selection: sequential increment on fetch, redirect in execute, hold otherwise.
  always_comb begin
    next_pc_s = pc_r;
    case (state_r)
      ST_IF: begin
        if (imem_ready) begin
          next_pc_s = pc_r + 32'd4;
        end else begin
          next_pc_s = pc_r;
        end
      end
      ST_EX: begin
        // In execute pc already points past the instruction, so offsets are relative to it.
        if (jump_flag) begin
          next_pc_s = jump_target(pc_r, instr_r);
        end else if (branch_flag && alu_zero) begin
          next_pc_s = branch_target(pc_r, instr_r);
        end else begin
          next_pc_s = pc_r;
        end
      end
      default: next_pc_s = pc_r;
    endcase
  end

  // FSM, PC and instruction register; a stalled fetch freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IF;
      pc_r    <= RESET_PC_ALIGNED;
      instr_r <= 32'h0000_0000;
    end else begin
      pc_r <= next_pc_s;
      case (state_r)
        ST_IF: begin
          if (fetch_done_s) begin
            instr_r <= imem_rdata;
            state_r <= next_state_s;
          end else begin
            instr_r <= instr_r;
            state_r <= state_r;
          end
        end
        default: begin
          instr_r <= instr_r;
          state_r <= next_state_s;
        end
      endcase
    end
  end

  assign imem_req  = (state_r == ST_IF) && !rst;
  assign stall     = imem_req && !imem_ready;
  assign imem_addr = pc_r;
  assign pc        = pc_r;
  assign instr     = instr_r;
  assign opcode    = instr_r[31:26];
  assign funct     = instr_r[5:0];
  assign state     = state_r;

endmodule

// File: tb/tb_fetch_state_unit.sv
// Self-checking bench for fetch_state_unit: directed scenarios plus a randomized run,
// all compared against a behavioural model of the fetch/redirect rules.
module tb_fetch_state_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  new_state;
  logic        branch_flag, jump_flag, alu_zero;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        imem_req;
  logic [31:0] imem_addr, pc, instr;
  logic [5:0]  opcode, funct;
  logic [2:0]  state;
  logic        stall;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_pc;
  logic [31:0] m_instr;
  int          m_state;

  always #5 clk = ~clk;

  fetch_state_unit dut (
    .clk(clk), .rst(rst), .new_state(new_state), .branch_flag(branch_flag),
    .jump_flag(jump_flag), .alu_zero(alu_zero), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .imem_req(imem_req), .imem_addr(imem_addr), .pc(pc),
    .instr(instr), .opcode(opcode), .funct(funct), .state(state), .stall(stall)
  );

  // Reference: states 0..4 are IF,ID,EX,MEM,WB; PC math is plain 32-bit arithmetic.
  task automatic tick();
    int off;
    @(posedge clk);
    if (rst) begin
      m_pc = 32'h0; m_instr = 32'h0; m_state = 0;
    end else if (m_state == 0) begin
      if (imem_ready) begin
        m_instr = imem_rdata;
        m_pc    = m_pc + 32'd4;
        m_state = (new_state <= 3'd4) ? int'(new_state) : 0;
      end
    end else begin
      if (m_state == 2) begin
        if (jump_flag) begin
          m_pc = (m_pc & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) * 32'd4);
        end else if (branch_flag && alu_zero) begin
          off  = int'($signed(m_instr[15:0])) * 4;
          m_pc = m_pc + 32'(off);
        end
      end
      m_state = (new_state <= 3'd4) ? int'(new_state) : 0;
    end
    @(negedge clk);
  endtask

  task automatic set_in(input logic r, input logic [2:0] ns, input logic br,
                        input logic jf, input logic z, input logic [31:0] rd,
                        input logic rdy);
    rst = r; new_state = ns; branch_flag = br; jump_flag = jf; alu_zero = z;
    imem_rdata = rd; imem_ready = rdy;
    #1;
  endtask

  task automatic do_reset();
    set_in(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    set_in(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  // IF -> ID -> EX -> IF for one instruction, with the given flags in EX.
  task automatic run_instr(input logic [31:0] word, input logic br, input logic jf,
                           input logic z);
    set_in(1'b0, 3'd1, 1'b0, 1'b0, 1'b0, word, 1'b1); tick();
    set_in(1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0); tick();
    set_in(1'b0, 3'd0, br, jf, z, 32'h0, 1'b0); tick();
  endtask

  task automatic test_reset();
    set_in(1'b1, 3'd2, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
    n_checks++;
    if (imem_req !== 1'b0 || stall !== 1'b0) begin
      n_errors++; $display("FAIL reset_req: req=%b stall=%b, expected 0 0", imem_req, stall);
    end
    tick();
    n_checks++;
    if (pc !== 32'h0 || instr !== 32'h0 || state !== 3'd0) begin
      n_errors++;
      $display("FAIL reset_state: pc=%h instr=%h state=%0d, expected 0 0 0", pc, instr, state);
    end
    set_in(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_fetch();
    do_reset();
    set_in(1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 32'h8C01_0004, 1'b1);
    n_checks++;
    if (imem_req !== 1'b1 || stall !== 1'b0 || imem_addr !== 32'h0) begin
      n_errors++;
      $display("FAIL fetch_req: req=%b stall=%b addr=%h, expected 1 0 0", imem_req, stall, imem_addr);
    end
    tick();
    n_checks++;
    if (state !== 3'd1 || pc !== 32'h4 || instr !== 32'h8C01_0004 || opcode !== 6'h23 ||
        funct !== 6'h04) begin
      n_errors++;
      $display("FAIL fetch_lw: state=%0d pc=%h instr=%h op=%h fn=%h, expected 1 4 8c010004 23 04",
               state, pc, instr, opcode, funct);
    end
    set_in(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_errors++; $display("FAIL fetch_req_id: req=%b, expected 0", imem_req);
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 3'd2, 1'b0, 1'b0, 1'b0, $urandom, 1'b0);
      n_checks++;
      if (stall !== 1'b1) begin
        n_errors++; $display("FAIL stall_flag: cycle %0d stall=%b, expected 1", i, stall);
      end
      tick();
      n_checks++;
      if (pc !== 32'h0 || instr !== 32'h0 || state !== 3'd0) begin
        n_errors++;
        $display("FAIL stall_hold: cycle %0d pc=%h instr=%h state=%0d, expected 0 0 0",
                 i, pc, instr, state);
      end
    end
    set_in(1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 1'b1);
    tick();
    n_checks++;
    if (pc !== 32'h4 || instr !== 32'h1234_5678 || state !== 3'd1) begin
      n_errors++;
      $display("FAIL stall_release: pc=%h instr=%h state=%0d, expected 4 12345678 1",
               pc, instr, state);
    end
  endtask

  task automatic test_branch();
    for (int z = 1; z >= 0; z--) begin
      do_reset();
      for (int i = 0; i < 4; i++) begin
        set_in(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1); tick();
      end
      n_checks++;
      if (imem_addr !== 32'h10) begin
        n_errors++; $display("FAIL branch_addr: addr=%h, expected 10", imem_addr);
      end
      run_instr(32'h1000_FFFC, 1'b1, 1'b0, z[0]);
      n_checks++;
      if (pc !== (z != 0 ? 32'h4 : 32'h14) || pc !== m_pc || state !== 3'd0) begin
        n_errors++;
        $display("FAIL branch_z%0d: pc=%h state=%0d, expected %h 0",
                 z, pc, state, (z != 0 ? 32'h4 : 32'h14));
      end
    end
  endtask

  task automatic test_jump();
    do_reset();
    run_instr(32'h1000_FFFB, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (pc !== 32'hFFFF_FFF0) begin
      n_errors++; $display("FAIL jump_setup_branch: pc=%h, expected fffffff0", pc);
    end
    run_instr(32'h0800_0000, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (pc !== 32'hF000_0000) begin
      n_errors++; $display("FAIL jump_to_f0: pc=%h, expected f0000000", pc);
    end
    run_instr(32'h0800_0100, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (pc !== 32'hF000_0400 || pc !== m_pc) begin
      n_errors++; $display("FAIL jump_priority: pc=%h, expected f0000400", pc);
    end
    // flags outside EX are ignored
    set_in(1'b0, 3'd1, 1'b1, 1'b1, 1'b1, 32'h0800_0200, 1'b1); tick();
    set_in(1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0); tick();
    n_checks++;
    if (pc !== 32'hF000_0404 || state !== 3'd3) begin
      n_errors++; $display("FAIL jump_ignored_in_id: pc=%h state=%0d, expected f0000404 3", pc, state);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    run_instr(32'h1000_FFFE, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (pc !== 32'hFFFF_FFFC) begin
      n_errors++; $display("FAIL wrap_setup: pc=%h, expected fffffffc", pc);
    end
    set_in(1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 32'hAAAA_5555, 1'b1); tick();
    n_checks++;
    if (pc !== 32'h0 || instr !== 32'hAAAA_5555) begin
      n_errors++; $display("FAIL wrap_pc: pc=%h instr=%h, expected 0 aaaa5555", pc, instr);
    end
  endtask

  task automatic test_illegal_and_reset();
    do_reset();
    set_in(1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 32'h0000_0020, 1'b1); tick();
    set_in(1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0); tick();
    n_checks++;
    if (state !== 3'd0 || pc !== 32'h4 || instr !== 32'h20) begin
      n_errors++;
      $display("FAIL illegal_state: state=%0d pc=%h instr=%h, expected 0 4 20", state, pc, instr);
    end
    set_in(1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 32'h0000_0021, 1'b1); tick();
    set_in(1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0); tick();
    set_in(1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0); tick();
    n_checks++;
    if (state !== 3'd3) begin
      n_errors++; $display("FAIL reach_mem: state=%0d, expected 3", state);
    end
    set_in(1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1); tick();
    n_checks++;
    if (pc !== 32'h0 || state !== 3'd0 || instr !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_in_mem: pc=%h state=%0d instr=%h, expected 0 0 0", pc, state, instr);
    end
    set_in(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_random();
    logic [2:0] ns;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      ns = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      set_in(($urandom_range(0, 40) == 0), ns, 1'($urandom), 1'($urandom_range(0, 3) == 0),
             1'($urandom), $urandom, ($urandom_range(0, 2) != 0));
      n_checks++;
      if (imem_req !== (m_state == 0 && !rst) ||
          stall !== (m_state == 0 && !rst && !imem_ready) || imem_addr !== m_pc) begin
        n_errors++;
        $display("FAIL rand_comb: cycle %0d req=%b stall=%b addr=%h, expected %b %b %h", i,
                 imem_req, stall, imem_addr, (m_state == 0 && !rst),
                 (m_state == 0 && !rst && !imem_ready), m_pc);
      end
      tick();
      n_checks++;
      if (pc !== m_pc || instr !== m_instr || state !== 3'(m_state) ||
          opcode !== m_instr[31:26] || funct !== m_instr[5:0]) begin
        n_errors++;
        $display("FAIL rand_regs: cycle %0d pc=%h instr=%h state=%0d, expected %h %h %0d",
                 i, pc, instr, state, m_pc, m_instr, m_state);
      end
    end
  endtask

  initial begin
    m_pc = 32'h0; m_instr = 32'h0; m_state = 0;
    set_in(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    test_reset();
    test_fetch();
    test_stall();
    test_branch();
    test_jump();
    test_wrap();
    test_illegal_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
